// File: rtl/divisor_seq_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the default operand width.
package divisor_seq_ctrl_pkg;

    localparam int DIV_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divisor_seq_ctrl_etapa_div.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, try to subtract the divisor, and keep the difference only when
// it does not borrow.
module etapa_div
    import divisor_seq_ctrl_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    // The full remainder is shifted (not just its low N-1 bits): when the
    // divisor exceeds 2^(N-1) the remainder MSB can be set and must survive.
    logic [N:0] shifted;
    logic [N:0] trial;

    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, divisor_i};

    // Because rem_i < divisor_i, shifted < 2*divisor_i; so a non-borrowing
    // trial is below the divisor (fits N bits) and a borrowing one wraps with
    // its MSB set, making trial[N] the borrow flag.
    assign q_o   = ~trial[N];
    assign rem_o = trial[N] ? shifted[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/divisor_seq_ctrl.sv
// Sequential restoring divider controller. A single etapa_div instance is
// reused once per CALC cycle, producing one quotient bit per cycle, MSB first.
// Assumes N >= 2.
module divisor_seq_ctrl
    import divisor_seq_ctrl_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic [N-1:0] Resto,
    output logic         R_exists,
    output logic         ERRO
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q;
    logic [N-1:0]  dividend_q;
    logic [N-1:0]  divisor_q;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  quot_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          rexists_q;
    logic          erro_q;

    logic [N-1:0]  step_rem_d;
    logic          step_bit_d;

    etapa_div #(
        .N(N)
    ) u_etapa (
        .rem_i    (rem_q),
        .bit_i    (dividend_q[N-1]),
        .divisor_i(divisor_q),
        .rem_o    (step_rem_d),
        .q_o      (step_bit_d)
    );

    // Control FSM plus operand/result registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rexists_q  <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dividend_q <= A;
                        divisor_q  <= B;
                        rem_q      <= '0;
                        quot_q     <= '0;
                        rexists_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        if (B == '0) begin
                            // Division by zero: skip the datapath, report at once.
                            erro_q  <= 1'b1;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            erro_q  <= 1'b0;
                            cnt_q   <= CW'(N - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dividend_q <= {dividend_q[N-2:0], 1'b0};
                    rem_q      <= step_rem_d;
                    quot_q     <= {quot_q[N-2:0], step_bit_d};
                    if (cnt_q == '0) begin
                        rexists_q <= (step_rem_d != '0);
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign S        = quot_q;
    assign Resto    = rem_q;
    assign R_exists = rexists_q;
    assign ERRO     = erro_q;

endmodule
